// File: rtl/pong_link_pkg.sv
// Shared definitions for the board-to-board pong state link.
// Holds the sync header, packet length, transmitter FSM states, the
// game-state snapshot struct and the payload byte/checksum helpers.
// The receiving block on the other board imports the same package.
package pong_link_pkg;

  localparam logic [7:0]  HEADER_BYTE   = 8'hA5;
  localparam int unsigned PKT_LEN       = 9;
  localparam int unsigned PAYLOAD_BYTES = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } frame_state_e;

  // 49 bits of game state; packed MSB-first in the order listed
  typedef struct packed {
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [9:0]  y_player1;
    logic [9:0]  y_player2;
    logic [3:0]  player1_score;
    logic [3:0]  player2_score;
  } game_state_t;

  // 56-bit payload: seven zero pad bits above the snapshot
  function automatic logic [55:0] pack_payload(input game_state_t s);
    return {7'b0, s};
  endfunction

  // Payload byte k (0 = P0, most significant)
  function automatic logic [7:0] payload_byte(input logic [55:0] p, input logic [2:0] k);
    return 8'(p >> (6'd48 - 6'd8 * 6'(k)));
  endfunction

  // XOR of P0..P6; the header is not covered
  function automatic logic [7:0] frame_checksum(input logic [55:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
      c = c ^ payload_byte(p, 3'(k));
    end
    return c;
  endfunction

endpackage

// File: rtl/state_frame_tx_if.sv
// Byte handshake between the state framer and the UART byte transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data is valid and held until accepted
//   tx_ready : transmitter accepts the byte on a cycle with tx_valid high
// master = framer side, slave = UART side.
interface state_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/state_frame_tx.sv
// Game-state packet framer: every FRAME_DIV enabled timing ticks it
// snapshots ball/paddle/score state and sends a 9-byte packet
// (HEADER, P0..P6, XOR checksum) over a valid/ready byte handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   timing_tick_i, enable_i  frame tick and link enable
//   x_ball_i .. player2_score_i  live game state
//   tx_if (master)           tx_data / tx_valid out, tx_ready in
//   frame_busy_o             packet in progress
//   frame_done_o             one-cycle pulse after the checksum is accepted
//   overrun_cnt_o            saturating count of dropped send requests
module state_frame_tx
  import pong_link_pkg::*;
#(
  parameter logic [7:0]  HEADER    = HEADER_BYTE,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    timing_tick_i,
  input  logic                    enable_i,
  input  logic [10:0]             x_ball_i,
  input  logic [9:0]              y_ball_i,
  input  logic [9:0]              y_player1_i,
  input  logic [9:0]              y_player2_i,
  input  logic [3:0]              player1_score_i,
  input  logic [3:0]              player2_score_i,
  state_frame_tx_if.master        tx_if,
  output logic                    frame_busy_o,
  output logic                    frame_done_o,
  output logic [7:0]              overrun_cnt_o
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [3:0] IDX_LAST = 4'(PKT_LEN - 1);

  frame_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [55:0]  payload_q, payload_d;
  logic [7:0]   div_q, div_d;
  logic         pending_q, pending_d;
  logic [7:0]   ovr_q, ovr_d;
  logic [7:0]   data_q, data_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         req_s;
  logic         accept_s;
  logic         launch_s;
  game_state_t  live_s;

  assign live_s = {x_ball_i, y_ball_i, y_player1_i, y_player2_i,
                   player1_score_i, player2_score_i};
  assign accept_s = valid_q & tx_if.tx_ready;

  // Packet byte i: 0 = header, 1..7 = payload, 8 = checksum
  function automatic logic [7:0] pkt_byte(input logic [55:0] p, input logic [3:0] i);
    logic [7:0] b;
    if (i == 4'd0) begin
      b = HEADER;
    end else if (i <= 4'd7) begin
      b = payload_byte(p, 3'(i - 4'd1));
    end else begin
      b = frame_checksum(p);
    end
    return b;
  endfunction

  // Frame divider: only enabled ticks advance; wrap raises a send request
  always_comb begin
    div_d = div_q;
    req_s = 1'b0;
    if (timing_tick_i && enable_i) begin
      if (div_q == DIV_LAST) begin
        div_d = 8'd0;
        req_s = 1'b1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      div_d = div_q;
    end
  end

  // FSM next state, byte sequencing, pending/overrun bookkeeping
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    launch_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch_s = req_s | pending_q;
      end
      ST_SEND: begin
        if (accept_s) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = pkt_byte(payload_q, idx_q + 4'd1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (launch_s) begin
      // A launch consumes the pending slot; a request arriving on the same
      // cycle as a pending-driven launch re-occupies it.
      state_d   = ST_SEND;
      idx_d     = 4'd0;
      payload_d = pack_payload(live_s);
      data_d    = HEADER;
      valid_d   = 1'b1;
      busy_d    = 1'b1;
      pending_d = pending_q & req_s;
    end else if (req_s) begin
      // Busy (SEND/DONE): one request may wait, further ones are dropped
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end else begin
        ovr_d = ovr_q;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      payload_q <= 56'd0;
      div_q     <= 8'd0;
      pending_q <= 1'b0;
      ovr_q     <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_if.tx_data  = data_q;
  assign tx_if.tx_valid = valid_q;
  assign frame_busy_o   = busy_q;
  assign frame_done_o   = done_q;
  assign overrun_cnt_o  = ovr_q;

endmodule

// File: tb/tb_state_frame_tx.sv
// Randomized self-checking bench for state_frame_tx.
// Two instances: dut1 (FRAME_DIV=1) for most scenarios, dut3 (FRAME_DIV=3)
// for the divider. Expected packets come from an arithmetic model of the
// payload layout; accepted bytes are captured by per-DUT monitors.
module tb_state_frame_tx;
  import pong_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick1, tick3, enable;
  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_p1, y_p2;
  logic [3:0]  s1, s2;
  logic        busy1, done1, busy3, done3;
  logic [7:0]  ovr1, ovr3;

  state_frame_tx_if if1();
  state_frame_tx_if if3();

  state_frame_tx #(.FRAME_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .timing_tick_i(tick1), .enable_i(enable),
    .x_ball_i(x_ball), .y_ball_i(y_ball), .y_player1_i(y_p1), .y_player2_i(y_p2),
    .player1_score_i(s1), .player2_score_i(s2), .tx_if(if1),
    .frame_busy_o(busy1), .frame_done_o(done1), .overrun_cnt_o(ovr1));

  state_frame_tx #(.FRAME_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .timing_tick_i(tick3), .enable_i(enable),
    .x_ball_i(x_ball), .y_ball_i(y_ball), .y_player1_i(y_p1), .y_player2_i(y_p2),
    .player1_score_i(s1), .player2_score_i(s2), .tx_if(if3),
    .frame_busy_o(busy3), .frame_done_o(done3), .overrun_cnt_o(ovr3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] acc1[$], acc3[$], exp1[$], exp3[$];
  int n_done1 = 0, n_done3 = 0;
  bit rand_ready = 1'b0, scramble = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: payload as a plain 56-bit number built from field weights
  function automatic logic [55:0] model_payload();
    return (56'(x_ball) << 38) | (56'(y_ball) << 28) | (56'(y_p1) << 18) |
           (56'(y_p2) << 8) | (56'(s1) << 4) | 56'(s2);
  endfunction

  function automatic logic [7:0] model_byte(input logic [55:0] p, input int k);
    logic [7:0] c;
    c = 8'h00;
    if (k == 0) return 8'hA5;
    if (k <= 7) return 8'((p >> (8 * (7 - k))) & 56'hFF);
    for (int j = 1; j <= 7; j++) c = c ^ 8'((p >> (8 * (7 - j))) & 56'hFF);
    return c;
  endfunction

  task automatic push_exp1();
    logic [55:0] p;
    p = model_payload();
    for (int k = 0; k < 9; k++) exp1.push_back(model_byte(p, k));
  endtask

  task automatic push_exp3();
    logic [55:0] p;
    p = model_payload();
    for (int k = 0; k < 9; k++) exp3.push_back(model_byte(p, k));
  endtask

  task automatic rand_inputs();
    x_ball = 11'($urandom); y_ball = 10'($urandom);
    y_p1 = 10'($urandom);   y_p2 = 10'($urandom);
    s1 = 4'($urandom);      s2 = 4'($urandom);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // dut1 monitor: capture accepted bytes, check hold-while-stalled, packet length, done latency
  initial begin
    int  cnt = 0, acc_cyc = 0;
    bit  stall = 1'b0;
    logic [7:0] stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("hold_valid", if1.tx_valid, 1);
          check_eq("hold_data", if1.tx_data, stall_data);
        end
        stall = if1.tx_valid && !if1.tx_ready;
        stall_data = if1.tx_data;
        if (if1.tx_valid && if1.tx_ready) begin
          acc1.push_back(if1.tx_data);
          cnt++;
          if (cnt == 9) acc_cyc = cyc + 1;
        end
        if (done1) begin
          n_done1++;
          check_eq("pkt_len", cnt, 9);
          check_eq("done_latency", cyc, acc_cyc);
          cnt = 0;
        end
      end
    end
  end

  // dut3 monitor: capture accepted bytes and done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if3.tx_valid && if3.tx_ready) acc3.push_back(if3.tx_data);
        if (done3) n_done3++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) if1.tx_ready = 1'($urandom_range(0, 1));
    if (scramble) rand_inputs();
  endtask

  task automatic pulse_tick1();
    tick1 = 1'b1;
    step();
    tick1 = 1'b0;
  endtask

  task automatic wait_done1(input int target, input int budget);
    int i = 0;
    while (n_done1 < target && i < budget) begin
      step();
      i++;
    end
    check_eq("done_timeout", n_done1 >= target, 1);
  endtask

  task automatic compare_q1(input string tag);
    check_eq({tag, "_count"}, acc1.size(), exp1.size());
    for (int k = 0; k < acc1.size() && k < exp1.size(); k++)
      check_eq(tag, acc1[k], exp1[k]);
    acc1.delete();
    exp1.delete();
  endtask

  initial begin
    logic [7:0] t1_ref [9];
    bit en_pat [11];
    int en_n, base;
    t1_ref = '{8'hA5, 8'h00, 8'h80, 8'h18, 8'h04, 8'hB0, 8'h64, 8'h39, 8'h71};
    en_pat = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1};

    rst = 1'b1; tick1 = 1'b0; tick3 = 1'b0; enable = 1'b1;
    if1.tx_ready = 1'b1; if3.tx_ready = 1'b1;
    x_ball = 11'd0; y_ball = 10'd0; y_p1 = 10'd0; y_p2 = 10'd0; s1 = 4'd0; s2 = 4'd0;
    repeat (3) step();
    check_eq("rst_valid", if1.tx_valid, 0);
    check_eq("rst_data", if1.tx_data, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_ovr", ovr1, 0);
    rst = 1'b0;
    step();

    // 1: fixed vector, ready always high
    x_ball = 11'd512; y_ball = 10'd384; y_p1 = 10'd300; y_p2 = 10'd100; s1 = 4'd3; s2 = 4'd9;
    push_exp1();
    check_eq("t1_idle_valid", if1.tx_valid, 0);
    pulse_tick1();
    check_eq("t1_lat_valid", if1.tx_valid, 1);
    check_eq("t1_lat_hdr", if1.tx_data, 8'hA5);
    check_eq("t1_busy", busy1, 1);
    wait_done1(1, 40);
    check_eq("t1_nbytes", acc1.size(), 9);
    for (int k = 0; k < 9 && k < acc1.size(); k++) check_eq("t1_ref_byte", acc1[k], t1_ref[k]);
    compare_q1("t1_byte");
    repeat (3) step();
    check_eq("t1_done_once", n_done1, 1);

    // 2: random ready, inputs scrambled mid-packet; then several random packets
    rand_ready = 1'b1;
    push_exp1();
    pulse_tick1();
    scramble = 1'b1;
    wait_done1(2, 300);
    scramble = 1'b0;
    compare_q1("t2_byte");
    for (int r = 0; r < 4; r++) begin
      rand_inputs();
      push_exp1();
      pulse_tick1();
      scramble = 1'b1;
      wait_done1(3 + r, 300);
      scramble = 1'b0;
      compare_q1("t2_rand_byte");
    end
    rand_ready = 1'b0;
    if1.tx_ready = 1'b1;
    step();

    // 3: ready low, three ticks while busy
    base = n_done1;
    if1.tx_ready = 1'b0;
    rand_inputs();
    push_exp1();
    pulse_tick1();
    step();
    pulse_tick1();
    check_eq("t3_ovr_after2", ovr1, 0);
    step();
    pulse_tick1();
    check_eq("t3_ovr_after3", ovr1, 1);
    rand_inputs();
    push_exp1();
    if1.tx_ready = 1'b1;
    wait_done1(base + 2, 100);
    repeat (20) step();
    check_eq("t3_two_pkts", n_done1, base + 2);
    compare_q1("t3_byte");
    check_eq("t3_ovr_final", ovr1, 1);

    // 4: FRAME_DIV=3 with disabled ticks interleaved
    en_n = 0;
    for (int i = 0; i < 11; i++) begin
      bit launch;
      rand_inputs();
      enable = en_pat[i];
      launch = 1'b0;
      if (en_pat[i]) begin
        en_n++;
        launch = (en_n % 3 == 0);
        if (launch) push_exp3();
      end
      tick3 = 1'b1;
      step();
      tick3 = 1'b0;
      enable = 1'b1;
      check_eq("t4_launch", if3.tx_valid, launch);
      repeat (14) step();
    end
    check_eq("t4_npkts", n_done3, 3);
    check_eq("t4_count", acc3.size(), exp3.size());
    for (int k = 0; k < acc3.size() && k < exp3.size(); k++) check_eq("t4_byte", acc3[k], exp3[k]);

    // 5: asynchronous reset while P3 is on the bus
    base = n_done1;
    rand_inputs();
    push_exp1();
    pulse_tick1();
    for (int i = 0; i < 20 && acc1.size() < 4; i++) step();
    check_eq("t5_p3", if1.tx_data, exp1[4]);
    if1.tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("t5_valid_async", if1.tx_valid, 0);
    check_eq("t5_busy_async", busy1, 0);
    check_eq("t5_data_async", if1.tx_data, 0);
    step();
    rst = 1'b0;
    acc1.delete();
    exp1.delete();
    step();
    if1.tx_ready = 1'b1;
    rand_inputs();
    push_exp1();
    pulse_tick1();
    check_eq("t5_hdr", if1.tx_data, 8'hA5);
    wait_done1(base + 1, 40);
    compare_q1("t5_byte");

    // 6: overrun counter saturation
    if1.tx_ready = 1'b0;
    rand_inputs();
    pulse_tick1();
    step();
    pulse_tick1();
    check_eq("t6_ovr_start", ovr1, 0);
    for (int i = 0; i < 300; i++) begin
      step();
      pulse_tick1();
      if (i == 0)   check_eq("t6_ovr_1", ovr1, 1);
      if (i == 253) check_eq("t6_ovr_254", ovr1, 254);
      if (i == 254) check_eq("t6_ovr_255", ovr1, 255);
    end
    check_eq("t6_ovr_sat", ovr1, 255);
    check_eq("t6_stall_valid", if1.tx_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/state_frame_tx.md
Name: state_frame_tx

Overview:
Serialises one game-state snapshot per video-frame tick into a 9-byte packet for the board-to-board UART link. The packet carries ball position, both paddle positions and both scores. The block sits between the game logic (state sources and timing_tick) and the UART byte transmitter that drives the tx pin. It talks to the UART through a valid/ready byte handshake.

Parameters:
HEADER, 8'hA5, sync byte sent first in every packet.
FRAME_DIV, 1, send one packet per FRAME_DIV accepted timing_tick pulses (1..255).

Ports:
clk  input  1  system clock (65 MHz pixel domain).
rst  input  1  reset, asynchronous, active-high.
timing_tick  input  1  one-cycle pulse per video frame.
enable  input  1  1 = link transmit on (master board); 0 = ticks ignored.
x_ball  input  11  ball x.
y_ball  input  10  ball y.
y_player1  input  10  paddle 1 y.
y_player2  input  10  paddle 2 y.
player1_score  input  4  score 1.
player2_score  input  4  score 2.
tx_data  output  8  byte to UART transmitter.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  UART can accept a byte.
frame_busy  output  1  packet in progress.
frame_done  output  1  one-cycle pulse after checksum byte accepted.
overrun_cnt  output  8  saturating count of dropped send requests.

Behaviour:
- Reset (async, any time, including mid-packet): tx_valid=0, tx_data=0, frame_busy=0, frame_done=0, overrun_cnt=0, divider=0, pending=0. State goes to IDLE. No partial packet resumes.
- Divider: a tick with enable=1 increments div_cnt. On div_cnt==FRAME_DIV-1 it wraps to 0 and raises a send request. Ticks with enable=0 are ignored and do not advance the counter.
- Payload: 56-bit vector {7'b0, x_ball, y_ball, y_player1, y_player2, player1_score, player2_score}. It is split into bytes P0..P6, MSB first.
- Packet, in order: HEADER, P0..P6, CHK. CHK = P0^P1^...^P6; HEADER is excluded.
- Snapshot: all inputs are registered into the payload register on the cycle the request is taken. The packet never changes while it is being sent.
- FSM states: IDLE, SEND, DONE.
  - IDLE + request: snapshot is taken, byte index idx=0, go to SEND. tx_valid=1 with HEADER on the next cycle (latency 1 clk from tick). frame_busy=1 from that same cycle.
  - SEND: tx_data and tx_valid are held stable until tx_valid&&tx_ready. On acceptance idx increments and the next byte appears on the following cycle; no gap is required beyond that. After idx 8 (CHK) is accepted, go to DONE.
  - DONE: one cycle. frame_done=1, tx_valid=0, frame_busy=0. Go to IDLE. If pending=1, pending is cleared and the next packet is launched as from IDLE.
- Request while busy (SEND/DONE): if pending=0, pending is set. If pending was already 1, the request is dropped and overrun_cnt increments, saturating at 255.
- Request in the same cycle as DONE: treated as pending, not overrun, unless pending was already set.
- enable deasserted mid-packet: the current packet completes. A pending request is still sent.
- tx_ready held low indefinitely: the block stalls in SEND with outputs stable. This is not an error.

Decomposition:
- Shared package pong_link_pkg holds: the HEADER value, the packet length constant (9), the state enum type, and a packed struct game_state_t (x_ball, y_ball, y_player1, y_player2, player1_score, player2_score). The receiving block on the other board reuses the same package.
- No sub-module is needed. The divider, FSM and payload mux stay in one module.

Test Plan:
1. FRAME_DIV=1, tx_ready=1, single tick with x_ball=512, y_ball=384, y_player1=300, y_player2=100, scores 3/9 -> bytes A5 00 80 18 04 B0 64 39 71. tx_valid rises 1 clk after the tick. frame_done pulses once, 1 clk after the 71 byte is accepted.
2. Same inputs, tx_ready toggled pseudo-randomly, and inputs changed mid-packet -> identical 9 bytes. tx_data is stable whenever tx_valid=1 and tx_ready=0.
3. tx_ready=0, three ticks while busy -> pending set by tick 2, overrun_cnt=1 after tick 3. On release, exactly two packets go out back to back and the second carries the state sampled at launch.
4. FRAME_DIV=3, 9 ticks with enable=1 plus 2 ticks with enable=0 interleaved -> exactly 3 packets, launched on the 3rd, 6th and 9th enabled ticks.
5. Assert rst in the middle of P3 -> tx_valid=0 and frame_busy=0 immediately, without waiting for a clock edge. After release, the next tick yields a full packet starting with A5.
6. 300 overruns with tx_ready=0 -> overrun_cnt saturates at 255 and does not wrap.
